// File: rtl/vga_pkg.sv
// Shared VGA timing types, standard mode tables, sync polarity and colour-bar constants.
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60  = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam vga_timing_t SVGA_800X600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // {r,g,b} on/off per bar, index 0 is the leftmost (white) bar
  localparam int NUM_BARS = 8;
  localparam logic [NUM_BARS-1:0][2:0] BAR_RGB =
    {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

  // One raster pipeline stage; bl is 1 for a visible pixel
  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } stage_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active/sync region decode and carry out.
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             carry
);
  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);

  assign carry  = inc && (cnt == LAST);
  assign active = cnt < ACT_END;
  assign sync   = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)          cnt <= '0;
    else if (clr || carry) cnt <= '0;
    else if (inc)        cnt <= cnt + 1'b1;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V counters, pixel requests and latency-aligned outputs.
// Define VGA_TEST_PATTERN_EN to add the pattern_sel input and the internal 8-bar colour pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = VGA_640X480_60.h.active,
  parameter int H_FP       = VGA_640X480_60.h.fp,
  parameter int H_SYNC     = VGA_640X480_60.h.sync,
  parameter int H_BP       = VGA_640X480_60.h.bp,
  parameter int V_ACTIVE   = VGA_640X480_60.v.active,
  parameter int V_FP       = VGA_640X480_60.v.fp,
  parameter int V_SYNC     = VGA_640X480_60.v.sync,
  parameter int V_BP       = VGA_640X480_60.v.bp,
  parameter bit H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int COLOR_W    = 4,
  parameter int CNT_W      = 11,
  parameter int PIPE_LAT   = 2
) (
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 pattern_sel,
`endif
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 px_req,
  output logic [CNT_W-1:0]     px_x,
  output logic [CNT_W-1:0]     px_y,
  output logic                 pix_ce,
  input  logic [3*COLOR_W-1:0] pix_rgb,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, h_sync, h_carry, v_act, v_sync, v_carry_unused;
  stage_t           st0;
  stage_t [PIPE_LAT:0] st_pipe;
  logic             fin_bl;
  logic [3*COLOR_W-1:0] src_rgb, rgb_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                        div_q <= '0;
    else if (!en || div_q == DIV_LAST) div_q <= '0;
    else                               div_q <= div_q + 1'b1;

  // rst_n gates the tick so that pulses stay low while reset is held, even with CLK_DIV=1
  assign pix_ce = rst_n && en && (div_q == DIV_LAST);

  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)) u_h (
    .clk(clk), .rst_n(rst_n), .clr(!en), .inc(pix_ce),
    .cnt(h_cnt), .active(h_act), .sync(h_sync), .carry(h_carry)
  );

  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)) u_v (
    .clk(clk), .rst_n(rst_n), .clr(!en), .inc(h_carry),
    .cnt(v_cnt), .active(v_act), .sync(v_sync), .carry(v_carry_unused)
  );

  assign st0         = '{hs: h_sync, vs: v_sync, bl: h_act && v_act};
  assign px_req      = st0.bl;
  assign px_x        = h_cnt;
  assign px_y        = v_cnt;
  assign line_start  = pix_ce && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / NUM_BARS;
  logic [CNT_W-1:0] bar_idx;
  logic [3:0]       pat0, fin_pat;  // {pattern_sel, bar r/g/b on}

  assign bar_idx = h_cnt / CNT_W'(BAR_W);
  assign pat0    = {pattern_sel,
                    BAR_RGB[(bar_idx > CNT_W'(NUM_BARS - 1)) ? 3'd7 : bar_idx[2:0]]};
  assign src_rgb = fin_pat[3] ? {{COLOR_W{fin_pat[2]}}, {COLOR_W{fin_pat[1]}}, {COLOR_W{fin_pat[0]}}}
                              : pix_rgb;
`else
  assign src_rgb = pix_rgb;
`endif

  // fin_* is the request-tick view that lines up with pix_rgb at the final register edge
  if (PIPE_LAT == 0) begin : g_fin
    assign fin_bl = st0.bl;
`ifdef VGA_TEST_PATTERN_EN
    assign fin_pat = pat0;
`endif
  end else begin : g_fin
    assign fin_bl = st_pipe[PIPE_LAT-1].bl;
`ifdef VGA_TEST_PATTERN_EN
    logic [PIPE_LAT-1:0][3:0] pat_pipe;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)      pat_pipe <= '0;
      else if (!en)    pat_pipe <= '0;
      else if (pix_ce) begin
        for (int i = PIPE_LAT - 1; i > 0; i--) pat_pipe[i] <= pat_pipe[i-1];
        pat_pipe[0] <= pat0;
      end
    assign fin_pat = pat_pipe[PIPE_LAT-1];
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_pipe <= '0;
      rgb_q   <= '0;
    end else if (!en) begin
      st_pipe <= '0;
      rgb_q   <= '0;
    end else if (pix_ce) begin
      for (int i = PIPE_LAT; i > 0; i--) st_pipe[i] <= st_pipe[i-1];
      st_pipe[0] <= st0;
      rgb_q      <= fin_bl ? src_rgb : '0;
    end

  assign hsync     = st_pipe[PIPE_LAT].hs ? H_SYNC_POL : !H_SYNC_POL;
  assign vsync     = st_pipe[PIPE_LAT].vs ? V_SYNC_POL : !V_SYNC_POL;
  assign blank_n   = st_pipe[PIPE_LAT].bl;
  assign {r, g, b} = rgb_q;

endmodule
